// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver and its users:
//   - prefix bytes that qualify the following scan code (extended / break)
//   - frame-state enumeration used by the receiver FSM
//   - scan codes the game logic cares about
//   - odd-parity helper used by the frame checker
// ----------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   // Game key scan codes (set 2, make codes)
   localparam logic [7:0] PS2_KEY_W     = 8'h1D;
   localparam logic [7:0] PS2_KEY_A     = 8'h1C;
   localparam logic [7:0] PS2_KEY_S     = 8'h1B;
   localparam logic [7:0] PS2_KEY_D     = 8'h23;
   localparam logic [7:0] PS2_KEY_SPACE = 8'h29;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   // A frame is good when data bits plus parity bit hold an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_rx_if
// Event bundle from the PS/2 receiver to the game controller.
//   code       : scan code of the last completed event (held)
//   code_valid : one-cycle pulse, code/code_break/code_ext valid this cycle
//   code_break : key release (break prefix seen)
//   code_ext   : extended key (extended prefix seen)
//   parity_err : one-cycle pulse on a parity failure
//   frame_err  : one-cycle pulse on bad stop bit or inter-edge timeout
// master = receiver (drives), slave = consumer (reads).
// ----------------------------------------------------------------------------
interface ps2_keyboard_rx_if;
   logic [7:0] code;
   logic       code_valid;
   logic       code_break;
   logic       code_ext;
   logic       parity_err;
   logic       frame_err;

   modport master (
      output code, code_valid, code_break, code_ext, parity_err, frame_err
   );

   modport slave (
      input code, code_valid, code_break, code_ext, parity_err, frame_err
   );
endinterface

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
// Brings an asynchronous PS/2 line into the clk domain.
//   clk, rst    : system clock, synchronous active-high reset
//   pin_i       : raw asynchronous pin
//   sync_o      : output of the SYNC_STAGES-deep synchroniser
//   level_o     : deglitched level (FILTER_EN=1) or one-cycle-delayed sync_o
//   fall_edge_o : one-cycle strobe, aligned with level_o going 1 -> 0
// All state initialises to 1 because an idle PS/2 bus is pulled high.
// SYNC_STAGES must be at least 2.
// ----------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter bit FILTER_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic sync_o,
   output logic level_o,
   output logic fall_edge_o
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   level_q, level_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   fall_q, fall_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
      level_d = level_q;
      cnt_d   = '0;
      if (!FILTER_EN) begin
         level_d = synced;
      end else if (synced != level_q) begin
         // Count the run of samples disagreeing with the current level; any
         // agreeing sample restarts the run, so short glitches never flip it.
         if (cnt_q == CNT_LAST) begin
            level_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      fall_d = level_q & ~level_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign sync_o      = synced;
   assign level_o     = level_q;
   assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_rx
// PS/2 keyboard receiver: samples 11-bit device-to-host frames, checks stop
// bit and odd parity, and folds E0/F0 prefixes into one qualified event.
//   clk, rst : system clock, synchronous active-high reset
//   PS2C     : raw PS/2 clock pin (asynchronous)
//   PS2D     : raw PS/2 data pin (asynchronous)
//   evt      : event bundle (code, code_valid, code_break, code_ext,
//              parity_err, frame_err), all registered
// Events and error pulses appear one clk after the stop-bit falling edge.
// ----------------------------------------------------------------------------
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      PS2C,
   input  logic                      PS2D,
   ps2_keyboard_rx_if.master         evt
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic fall_edge;
   logic data_s;
   logic clk_sync_unused, clk_level_unused;
   logic dat_level_unused, dat_fall_unused;
   logic unused_taps;

   ps2_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .FILTER_EN   (1'b1)
   ) u_clk_filter (
      .clk         (clk),
      .rst         (rst),
      .pin_i       (PS2C),
      .sync_o      (clk_sync_unused),
      .level_o     (clk_level_unused),
      .fall_edge_o (fall_edge)
   );

   // Data only needs synchronising: it is stable around the clock edge.
   ps2_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .FILTER_EN   (1'b0)
   ) u_dat_sync (
      .clk         (clk),
      .rst         (rst),
      .pin_i       (PS2D),
      .sync_o      (data_s),
      .level_o     (dat_level_unused),
      .fall_edge_o (dat_fall_unused)
   );

   assign unused_taps = ^{clk_sync_unused, clk_level_unused, dat_level_unused, dat_fall_unused};

   ps2_state_e       state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [7:0]       code_q, code_d;
   logic             code_valid_q, code_valid_d;
   logic             code_break_q, code_break_d;
   logic             code_ext_q, code_ext_d;
   logic             parity_err_q, parity_err_d;
   logic             frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      to_cnt_d     = to_cnt_q + 1'b1;
      ext_d        = ext_q;
      brk_d        = brk_q;
      code_d       = code_q;
      code_break_d = code_break_q;
      code_ext_d   = code_ext_q;
      code_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // A high sample here is not a start bit; ignore it silently.
            if (fall_edge && !data_s) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fall_edge) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall_edge) begin
               par_d   = data_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall_edge) begin
               state_d = IDLE;
               // A bad stop bit takes priority over a parity failure.
               if (!data_s) begin
                  frame_err_d = 1'b1;
                  ext_d       = 1'b0;
                  brk_d       = 1'b0;
               end else if (!ps2_odd_parity_ok(shift_q, par_q)) begin
                  parity_err_d = 1'b1;
                  ext_d        = 1'b0;
                  brk_d        = 1'b0;
               end else if (shift_q == PS2_PREFIX_EXT) begin
                  ext_d = 1'b1;
               end else if (shift_q == PS2_PREFIX_BRK) begin
                  brk_d = 1'b1;
               end else begin
                  code_d       = shift_q;
                  code_break_d = brk_q;
                  code_ext_d   = ext_q;
                  code_valid_d = 1'b1;
                  ext_d        = 1'b0;
                  brk_d        = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Inter-edge watchdog; an edge in the expiry cycle keeps the frame alive.
      if (state_q == IDLE || fall_edge) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
         to_cnt_d    = '0;
         state_d     = IDLE;
         frame_err_d = 1'b1;
         ext_d       = 1'b0;
         brk_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         to_cnt_q     <= '0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         code_break_q <= 1'b0;
         code_ext_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         to_cnt_q     <= to_cnt_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         code_break_q <= code_break_d;
         code_ext_q   <= code_ext_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Frame payload needs no reset: it is fully rewritten before each use.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign evt.code       = code_q;
   assign evt.code_valid = code_valid_q;
   assign evt.code_break = code_break_q;
   assign evt.code_ext   = code_ext_q;
   assign evt.parity_err = parity_err_q;
   assign evt.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Host-side PS/2 frame driver with a byte-level reference model feeding an
// expectation queue; a monitor pops and compares on every DUT output pulse.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_rx;
   import ps2_pkg::*;

   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 2000;
   localparam int HALF       = 100;   // half of the 200-clk PS/2 bit period

   localparam int K_VALID = 1;
   localparam int K_PERR  = 2;
   localparam int K_FERR  = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic PS2C = 1'b1;
   logic PS2D = 1'b1;

   always #5 clk = ~clk;

   ps2_keyboard_rx_if evt ();

   ps2_keyboard_rx #(
      .SYNC_STAGES    (2),
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .PS2C (PS2C),
      .PS2D (PS2D),
      .evt  (evt)
   );

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      longint     t_ref;
      int         lo;
      int         hi;
   } exp_t;

   exp_t   expq[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   longint cyc      = 0;
   logic   m_ext    = 1'b0;
   logic   m_brk    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Byte-level protocol model: prefixes accumulate, any error or a
   // delivered key clears them.
   function automatic void model_frame(input logic [7:0] b, input bit par_bad,
                                       input bit stop_bad, input longint t);
      exp_t e;
      e.kind = 0; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0;
      e.t_ref = t; e.lo = 3; e.hi = 20;
      if (stop_bad) begin
         e.kind = K_FERR; expq.push_back(e);
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (par_bad) begin
         e.kind = K_PERR; expq.push_back(e);
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         e.kind = K_VALID; e.code = b; e.brk = m_brk; e.ext = m_ext;
         expq.push_back(e);
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endfunction

   // Drives the first nfall bits of a frame. mode: 0 = no expectation,
   // 1 = full frame through the model, 2 = abandoned frame (timeout expected).
   task automatic send_bits(input logic [10:0] bits, input int nfall, input int mode,
                            input logic [7:0] b, input bit par_bad, input bit stop_bad);
      exp_t e;
      for (int i = 0; i < nfall; i++) begin
         PS2D = bits[i];
         clks(HALF / 2);
         if (i == nfall - 1) begin
            if (mode == 1) begin
               model_frame(b, par_bad, stop_bad, cyc);
            end else if (mode == 2) begin
               e.kind = K_FERR; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0;
               e.t_ref = cyc; e.lo = TIMEOUT - 5; e.hi = TIMEOUT + 30;
               expq.push_back(e);
               m_ext = 1'b0; m_brk = 1'b0;
            end
         end
         PS2C = 1'b0;
         clks(HALF);
         PS2C = 1'b1;
         clks(HALF / 2);
      end
      PS2D = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
      logic [10:0] bits;
      logic        par;
      par  = (~^b) ^ par_bad;
      bits = {~stop_bad, par, b, 1'b0};
      send_bits(bits, 11, 1, b, par_bad, stop_bad);
      clks(50);
   endtask

   // Monitor: every output pulse must match the head of the expectation queue.
   initial begin
      int     act_kind;
      longint dly;
      exp_t   e;
      forever begin
         @(negedge clk);
         if (!rst && (evt.code_valid || evt.parity_err || evt.frame_err)) begin
            act_kind = {29'd0, evt.frame_err, evt.parity_err, evt.code_valid};
            if (expq.size() == 0) begin
               check("unexpected_pulse", act_kind, 0);
            end else begin
               e = expq.pop_front();
               check("event_kind", act_kind, e.kind);
               if (e.kind == K_VALID) begin
                  check("code", evt.code, e.code);
                  check("code_break", evt.code_break, e.brk);
                  check("code_ext", evt.code_ext, e.ext);
               end
               dly = cyc - e.t_ref;
               n_checks++;
               if (dly < e.lo || dly > e.hi) begin
                  n_fail++;
                  $display("FAIL latency: got %0d clk, expected %0d..%0d", dly, e.lo, e.hi);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d events still expected", expq.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rb;
      bit         pb, sb;
      int         r;

      rst = 1'b1;
      clks(5);
      check("rst_code", evt.code, 0);
      check("rst_valid", evt.code_valid, 0);
      check("rst_break", evt.code_break, 0);
      check("rst_ext", evt.code_ext, 0);
      check("rst_perr", evt.parity_err, 0);
      check("rst_ferr", evt.frame_err, 0);
      rst = 1'b0;
      clks(20);

      // Plain make code, release, extended release, flags cleared afterwards
      send_frame(PS2_KEY_A, 0, 0);
      send_frame(PS2_PREFIX_BRK, 0, 0);
      send_frame(PS2_KEY_A, 0, 0);
      send_frame(PS2_PREFIX_EXT, 0, 0);
      send_frame(PS2_PREFIX_BRK, 0, 0);
      send_frame(8'h74, 0, 0);
      send_frame(PS2_KEY_A, 0, 0);

      // Parity error, then normal decode resumes
      send_frame(PS2_KEY_A, 1, 0);
      send_frame(PS2_PREFIX_BRK, 0, 0);
      send_frame(PS2_KEY_A, 0, 0);

      // Prefix pending when a parity error arrives must be dropped
      send_frame(PS2_PREFIX_EXT, 0, 0);
      send_frame(PS2_KEY_W, 1, 0);
      send_frame(PS2_KEY_D, 0, 0);

      // Stop-bit error with bad parity reports only frame_err
      send_frame(PS2_KEY_S, 1, 1);
      send_frame(PS2_KEY_S, 0, 0);

      // Timeout: start + 5 data bits, then silence
      send_bits({1'b1, 1'b0, PS2_KEY_W, 1'b0}, 6, 2, 8'h00, 0, 0);
      clks(2500);
      send_frame(PS2_KEY_D, 0, 0);

      // 2-clk glitch on PS2C with data low must not start a frame
      PS2D = 1'b0;
      clks(10);
      PS2C = 1'b0;
      clks(2);
      PS2C = 1'b1;
      clks(20);
      PS2D = 1'b1;
      clks(20);
      send_frame(PS2_KEY_A, 0, 0);

      // Reset after bit 4 with a break prefix pending
      send_frame(PS2_PREFIX_BRK, 0, 0);
      send_bits({1'b1, 1'b0, PS2_KEY_SPACE, 1'b0}, 5, 0, 8'h00, 0, 0);
      rst = 1'b1;
      clks(1);
      check("midrst_code", evt.code, 0);
      check("midrst_valid", evt.code_valid, 0);
      check("midrst_break", evt.code_break, 0);
      check("midrst_ext", evt.code_ext, 0);
      check("midrst_perr", evt.parity_err, 0);
      check("midrst_ferr", evt.frame_err, 0);
      m_ext = 1'b0;
      m_brk = 1'b0;
      rst = 1'b0;
      clks(300);
      send_frame(PS2_KEY_SPACE, 0, 0);

      // Random traffic with prefixes and occasional errors
      for (int n = 0; n < 14; n++) begin
         r  = $urandom_range(0, 9);
         rb = 8'($urandom);
         if (r < 2) rb = PS2_PREFIX_EXT;
         else if (r < 4) rb = PS2_PREFIX_BRK;
         pb = ($urandom_range(0, 9) == 0);
         sb = ($urandom_range(0, 14) == 0);
         send_frame(rb, pb, sb);
      end

      clks(300);
      check("queue_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
